// File: rtl/iopmp_chk_sched.sv
// Shares one IOPMP rule checker among several requesters: round-robin grant, one check in
// flight, per-channel response handshake, and a sticky first-error record with a drop counter.
package iopmp_pkg;
    parameter int SourceWidth = 8;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_READ  = 2'd1,
        REQ_WRITE = 2'd2,
        REQ_EXEC  = 2'd3
    } iopmp_req_e;

    typedef struct packed {
        logic [SourceWidth-1:0] rrid;
        logic [8:0]             eid;
    } err_reqid_t;

    typedef struct packed {
        logic        iopmp_fail;
        logic [1:0]  ttype;
        logic [2:0]  etype;
        logic [31:0] err_reqaddr;
        logic [31:0] err_reqaddrh;
        err_reqid_t  err_reqid;
    } error_report_t;
endpackage

// state  | meaning
// IDLE   | arbitrate; grant one valid channel and latch its request
// ISSUE  | one-cycle launch strobe to the checker
// WAIT   | count down until the checker result is due, then sample it
// RESP   | present result to the granted channel until it accepts
module iopmp_chk_sched
    import iopmp_pkg::*;
#(
    parameter int IOPMPNumChan = 4,
    parameter int CheckLatency = 2
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [IOPMPNumChan-1:0]                   req_valid_i,
    input  logic [IOPMPNumChan-1:0][33:0]             req_addr_i,
    input  iopmp_req_e [IOPMPNumChan-1:0]             req_type_i,
    input  logic [IOPMPNumChan-1:0][SourceWidth-1:0]  req_id_i,
    output logic [IOPMPNumChan-1:0]                   req_ready_o,
    output logic [IOPMPNumChan-1:0]                   resp_valid_o,
    output logic [IOPMPNumChan-1:0]                   resp_err_o,
    output logic [IOPMPNumChan-1:0][8:0]              resp_eid_o,
    input  logic [IOPMPNumChan-1:0]                   resp_ready_i,
    output logic                                      chk_valid_o,
    output logic [33:0]                               chk_addr_o,
    output iopmp_req_e                                chk_type_o,
    output logic [3:0]                                chk_chan_o,
    input  logic                                      chk_err_i,
    input  logic [8:0]                                chk_eid_i,
    output logic                                      err_valid_o,
    output error_report_t                             err_rec_o,
    output logic [7:0]                                err_drop_o,
    input  logic                                      err_clr_i
);
    localparam int ChanW = (IOPMPNumChan > 1) ? $clog2(IOPMPNumChan) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [ChanW-1:0]       rr_ptr_q;
    logic [ChanW-1:0]       chan_q;
    logic [33:0]            addr_q;
    iopmp_req_e             type_q;
    logic [SourceWidth-1:0] id_q;
    logic [3:0]             cnt_q;
    logic                   err_q;
    logic [8:0]             eid_q;
    logic                   err_valid_q;
    error_report_t          err_rec_q;
    logic [7:0]             err_drop_q;

    logic                   gnt_found;
    logic [ChanW-1:0]       gnt_idx;
    logic [ChanW:0]         cand;
    logic                   resp_hs;
    logic                   capture;
    error_report_t          new_rec;

    // Scan channels starting at rr_ptr, wrapping at IOPMPNumChan.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < IOPMPNumChan; i++) begin
            cand = {1'b0, rr_ptr_q} + (ChanW+1)'(i);
            if (cand >= (ChanW+1)'(IOPMPNumChan)) begin
                cand = cand - (ChanW+1)'(IOPMPNumChan);
            end
            if (!gnt_found && req_valid_i[cand[ChanW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[ChanW-1:0];
            end
        end
    end

    // The grant is gated by rst so no ready can leak out while reset is held.
    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        chk_valid_o = 1'b0;
        resp_hs     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_found && rst) begin
                    req_ready_o[gnt_idx] = 1'b1;
                    state_d              = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                chk_valid_o = 1'b1;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready_i[chan_q]) begin
                    resp_hs = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        resp_valid_o = '0;
        resp_err_o   = '0;
        resp_eid_o   = '0;
        if (state_q == ST_RESP) begin
            resp_valid_o[chan_q] = 1'b1;
            resp_err_o[chan_q]   = err_q;
            resp_eid_o[chan_q]   = eid_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            chan_q   <= '0;
            addr_q   <= '0;
            type_q   <= REQ_NONE;
            id_q     <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            eid_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_found) begin
                        chan_q   <= gnt_idx;
                        addr_q   <= req_addr_i[gnt_idx];
                        type_q   <= req_type_i[gnt_idx];
                        id_q     <= req_id_i[gnt_idx];
                        rr_ptr_q <= (gnt_idx == ChanW'(IOPMPNumChan-1)) ? '0 : gnt_idx + ChanW'(1);
                    end
                end
                ST_ISSUE: cnt_q <= 4'(CheckLatency-1);
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        err_q <= chk_err_i;
                        eid_q <= chk_err_i ? chk_eid_i : 9'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        new_rec                  = '0;
        new_rec.iopmp_fail       = 1'b1;
        new_rec.ttype            = type_q;
        new_rec.etype            = {1'b0, type_q};
        new_rec.err_reqaddr      = addr_q[33:2];
        new_rec.err_reqaddrh     = '0;
        new_rec.err_reqid.rrid   = id_q;
        new_rec.err_reqid.eid    = eid_q;
    end

    assign capture = resp_hs & err_q;

    // A clear in the same cycle as a new deny lets the new record in without counting a drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_valid_q <= 1'b0;
            err_rec_q   <= '0;
            err_drop_q  <= '0;
        end else if (capture && (!err_valid_q || err_clr_i)) begin
            err_rec_q   <= new_rec;
            err_valid_q <= 1'b1;
            if (err_clr_i) begin
                err_drop_q <= '0;
            end
        end else if (capture) begin
            if (err_drop_q != 8'hFF) begin
                err_drop_q <= err_drop_q + 8'd1;
            end
        end else if (err_clr_i) begin
            err_valid_q <= 1'b0;
            err_drop_q  <= '0;
        end
    end

    assign chk_addr_o  = addr_q;
    assign chk_type_o  = type_q;
    assign chk_chan_o  = 4'(chan_q);
    assign err_valid_o = err_valid_q;
    assign err_rec_o   = err_rec_q;
    assign err_drop_o  = err_drop_q;

endmodule

// File: tb/tb_iopmp_chk_sched.sv
// Self-checking bench for iopmp_chk_sched: behavioural arbiter/error model with a response
// scoreboard, a checker stub answering exactly at the sample cycle, plus table and corner sequences.
module tb_iopmp_chk_sched;
    import iopmp_pkg::*;

    localparam int N = 4;
    localparam int L = 2;

    logic                          clk = 1'b0;
    logic                          rst = 1'b0;
    logic [N-1:0]                  req_valid_i;
    logic [N-1:0][33:0]            req_addr_i;
    iopmp_req_e [N-1:0]            req_type_i;
    logic [N-1:0][SourceWidth-1:0] req_id_i;
    logic [N-1:0]                  req_ready_o;
    logic [N-1:0]                  resp_valid_o;
    logic [N-1:0]                  resp_err_o;
    logic [N-1:0][8:0]             resp_eid_o;
    logic [N-1:0]                  resp_ready_i;
    logic                          chk_valid_o;
    logic [33:0]                   chk_addr_o;
    iopmp_req_e                    chk_type_o;
    logic [3:0]                    chk_chan_o;
    logic                          chk_err_i;
    logic [8:0]                    chk_eid_i;
    logic                          err_valid_o;
    error_report_t                 err_rec_o;
    logic [7:0]                    err_drop_o;
    logic                          err_clr_i;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] cfg_eid  = '0;

    always #5 clk = ~clk;

    iopmp_chk_sched #(.IOPMPNumChan(N), .CheckLatency(L)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_type_i(req_type_i),
        .req_id_i(req_id_i), .req_ready_o(req_ready_o),
        .resp_valid_o(resp_valid_o), .resp_err_o(resp_err_o), .resp_eid_o(resp_eid_o),
        .resp_ready_i(resp_ready_i),
        .chk_valid_o(chk_valid_o), .chk_addr_o(chk_addr_o), .chk_type_o(chk_type_o),
        .chk_chan_o(chk_chan_o), .chk_err_i(chk_err_i), .chk_eid_i(chk_eid_i),
        .err_valid_o(err_valid_o), .err_rec_o(err_rec_o), .err_drop_o(err_drop_o),
        .err_clr_i(err_clr_i)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s timed out t=%0t", name, $time);
    endtask

    function automatic error_report_t mk_rec(input logic [33:0] a, input iopmp_req_e t,
                                             input logic [7:0] id, input logic [8:0] eid);
        error_report_t r;
        r                = '0;
        r.iopmp_fail     = 1'b1;
        r.ttype          = t;
        r.etype          = {1'b0, t};
        r.err_reqaddr    = a[33:2];
        r.err_reqid.rrid = id;
        r.err_reqid.eid  = eid;
        return r;
    endfunction

    // Checker stub: deny when addr[33] is set; correct answer only in the sample cycle.
    initial begin : checker_model
        logic       armed;
        int         cd;
        logic       a_err;
        logic [8:0] a_eid;
        armed = 1'b0; cd = 0; a_err = 1'b0; a_eid = '0;
        chk_err_i = 1'b0; chk_eid_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                armed = 1'b0;
            end else if (chk_valid_o) begin
                armed = 1'b1;
                cd    = L;
                a_err = chk_addr_o[33];
                a_eid = a_err ? cfg_eid : 9'($urandom);
            end else if (armed) begin
                if (cd == 0) armed = 1'b0;
                else cd--;
            end
            if (armed && cd == 0) begin
                chk_err_i = a_err;
                chk_eid_i = a_eid;
            end else begin
                chk_err_i = ~a_err;
                chk_eid_i = 9'($urandom);
            end
        end
    end

    typedef struct {
        int          chan;
        logic        err;
        logic [8:0]  eid;
        logic [33:0] addr;
        iopmp_req_e  typ;
        logic [7:0]  id;
        int          due;
    } sb_t;

    sb_t sb_q[$];

    // Cycle-level model and scoreboard, sampled on the falling edge.
    initial begin : monitor
        int                gchan;
        int                cyc;
        int                m_rr;
        int                m_gcyc;
        logic              m_busy;
        logic              m_ev;
        logic [7:0]        m_drop;
        error_report_t     m_rec;
        logic [N-1:0]      exp_ready, exp_rv, exp_re;
        logic [N-1:0][8:0] exp_eid;
        logic              exp_chk, hs, cap;
        sb_t               e;
        cyc = 0; m_rr = 0; m_gcyc = 0; m_busy = 1'b0; m_ev = 1'b0; m_drop = '0; m_rec = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                m_busy = 1'b0; m_rr = 0; m_ev = 1'b0; m_drop = '0; m_rec = '0;
                sb_q.delete();
            end else begin
                gchan = -1;
                exp_ready = '0;
                if (!m_busy) begin
                    for (int i = 0; i < N; i++) begin
                        if (gchan < 0 && req_valid_i[(m_rr + i) % N]) gchan = (m_rr + i) % N;
                    end
                end
                if (gchan >= 0) exp_ready[gchan] = 1'b1;
                check("req_ready", 128'(req_ready_o), 128'(exp_ready));

                exp_chk = m_busy && (cyc == m_gcyc + 1);
                check("chk_valid", 128'(chk_valid_o), 128'(exp_chk));
                if (exp_chk && sb_q.size() > 0) begin
                    check("chk_chan", 128'(chk_chan_o), 128'(sb_q[0].chan));
                    check("chk_addr", 128'(chk_addr_o), 128'(sb_q[0].addr));
                    check("chk_type", 128'(chk_type_o), 128'(sb_q[0].typ));
                end

                exp_rv = '0; exp_re = '0; exp_eid = '0; hs = 1'b0;
                if (sb_q.size() > 0 && cyc >= sb_q[0].due) begin
                    exp_rv[sb_q[0].chan]  = 1'b1;
                    exp_re[sb_q[0].chan]  = sb_q[0].err;
                    exp_eid[sb_q[0].chan] = sb_q[0].eid;
                    hs = resp_ready_i[sb_q[0].chan];
                end
                check("resp_valid", 128'(resp_valid_o), 128'(exp_rv));
                check("resp_err", 128'(resp_err_o), 128'(exp_re));
                check("resp_eid", 128'(resp_eid_o), 128'(exp_eid));

                check("err_valid", 128'(err_valid_o), 128'(m_ev));
                check("err_drop", 128'(err_drop_o), 128'(m_drop));
                check("err_rec", 128'(err_rec_o), 128'(m_rec));

                cap = 1'b0;
                if (hs) begin
                    e = sb_q.pop_front();
                    m_busy = 1'b0;
                    cap = e.err;
                    if (cap && (!m_ev || err_clr_i)) begin
                        m_rec = mk_rec(e.addr, e.typ, e.id, e.eid);
                        m_ev  = 1'b1;
                        if (err_clr_i) m_drop = '0;
                    end else if (cap) begin
                        if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
                    end
                end
                if (!cap && err_clr_i) begin
                    m_ev = 1'b0;
                    m_drop = '0;
                end

                if (gchan >= 0) begin
                    e.chan = gchan;
                    e.err  = req_addr_i[gchan][33];
                    e.eid  = e.err ? cfg_eid : 9'd0;
                    e.addr = req_addr_i[gchan];
                    e.typ  = req_type_i[gchan];
                    e.id   = req_id_i[gchan];
                    e.due  = cyc + 2 + L;
                    sb_q.push_back(e);
                    m_busy = 1'b1;
                    m_gcyc = cyc;
                    m_rr   = (gchan + 1) % N;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_req(input int ch, input logic [33:0] a, input iopmp_req_e t,
                          input logic [7:0] id, input logic clr_at_resp,
                          output logic got_err, output logic [8:0] got_eid, output int lat);
        logic granted;
        granted = 1'b0; got_err = 1'b0; got_eid = '0; lat = -1;
        req_addr_i[ch] = a; req_type_i[ch] = t; req_id_i[ch] = id; req_valid_i[ch] = 1'b1;
        for (int n = 0; n < 40 && !granted; n++) begin
            #1;
            if (req_ready_o[ch]) granted = 1'b1;
            step();
        end
        req_valid_i[ch] = 1'b0;
        if (!granted) begin
            timeout("grant");
            return;
        end
        #1;
        check("issue_strobe", 128'(chk_valid_o), 128'(1));
        lat = 1;
        while (!resp_valid_o[ch] && lat < 40) begin
            step();
            lat++;
        end
        if (!resp_valid_o[ch]) begin
            timeout("response");
            return;
        end
        got_err = resp_err_o[ch];
        got_eid = resp_eid_o[ch];
        if (clr_at_resp) err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
    endtask

    typedef struct {
        int          chan;
        logic [33:0] addr;
        iopmp_req_e  typ;
        logic [7:0]  id;
        logic [8:0]  eid_cfg;
        logic        exp_err;
        logic [8:0]  exp_eid;
    } vec_t;

    vec_t vecs[6];

    initial begin : main
        logic       g_err;
        logic [8:0] g_eid;
        int         lat;
        int         ng;
        int         gch[5];
        int         gcy[5];
        int         waited;
        error_report_t first_rec, clr_rec;

        vecs[0] = '{1, 34'h0_0000_0100, REQ_READ,  8'h05, 9'h000, 1'b0, 9'h000};
        vecs[1] = '{2, 34'h2_0000_0040, REQ_WRITE, 8'h33, 9'h007, 1'b1, 9'h007};
        vecs[2] = '{0, 34'h0_FFFF_FFFC, REQ_EXEC,  8'h80, 9'h003, 1'b0, 9'h000};
        vecs[3] = '{3, 34'h3_FFFF_FFFF, REQ_READ,  8'hFF, 9'h1FF, 1'b1, 9'h1FF};
        vecs[4] = '{0, 34'h2_0000_0000, REQ_EXEC,  8'h01, 9'h000, 1'b1, 9'h000};
        vecs[5] = '{3, 34'h1_2345_6780, REQ_WRITE, 8'h07, 9'h055, 1'b0, 9'h000};

        req_valid_i = '0; req_addr_i = '0; req_id_i = '0; resp_ready_i = '1; err_clr_i = 1'b0;
        for (int c = 0; c < N; c++) req_type_i[c] = REQ_NONE;

        req_valid_i = '1;
        repeat (3) step();
        #1;
        check("rst_req_ready", 128'(req_ready_o), 128'(0));
        check("rst_chk_valid", 128'(chk_valid_o), 128'(0));
        check("rst_err_valid", 128'(err_valid_o), 128'(0));
        check("rst_err_rec", 128'(err_rec_o), 128'(0));
        req_valid_i = '0;
        rst = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            cfg_eid = vecs[i].eid_cfg;
            do_req(vecs[i].chan, vecs[i].addr, vecs[i].typ, vecs[i].id, 1'b0, g_err, g_eid, lat);
            check("vec_err", 128'(g_err), 128'(vecs[i].exp_err));
            check("vec_eid", 128'(g_eid), 128'(vecs[i].exp_eid));
            if (i == 0) check("resp_latency", 128'(lat), 128'(2 + L));
            if (i == 1) begin
                check("first_err_valid", 128'(err_valid_o), 128'(1));
                check("first_rec_eid", 128'(err_rec_o.err_reqid.eid), 128'(vecs[1].exp_eid));
                check("first_rec_rrid", 128'(err_rec_o.err_reqid.rrid), 128'(vecs[1].id));
            end
        end

        for (int c = 0; c < N; c++) begin
            req_addr_i[c] = 34'h0_0000_1000 * 34'(c);
            req_type_i[c] = REQ_READ;
            req_id_i[c]   = 8'(8'h10 + c);
        end
        req_valid_i = '1;
        ng = 0;
        for (int k = 0; k < 40 && ng < 5; k++) begin
            #1;
            for (int c = 0; c < N; c++) begin
                if (req_ready_o[c] && ng < 5) begin
                    gch[ng] = c;
                    gcy[ng] = k;
                    ng++;
                end
            end
            step();
        end
        req_valid_i = '0;
        if (ng < 5) begin
            timeout("rr_grants");
        end else begin
            for (int k = 0; k < 5; k++) check("rr_order", 128'(gch[k]), 128'(k % N));
            for (int k = 1; k < 5; k++) check("rr_gap", 128'(gcy[k] - gcy[k-1]), 128'(3 + L));
        end
        repeat (10) step();

        first_rec = mk_rec(vecs[1].addr, vecs[1].typ, vecs[1].id, vecs[1].exp_eid);
        for (int k = 0; k < 300; k++) begin
            cfg_eid = 9'(k);
            do_req(2, 34'h2_0000_0100 + 34'(k * 4), REQ_READ, 8'h44, 1'b0, g_err, g_eid, lat);
        end
        #1;
        check("drop_saturated", 128'(err_drop_o), 128'(255));
        check("rec_kept", 128'(err_rec_o), 128'(first_rec));
        check("valid_kept", 128'(err_valid_o), 128'(1));

        cfg_eid = 9'h1A5;
        clr_rec = mk_rec(34'h2_8000_0010, REQ_EXEC, 8'hC3, 9'h1A5);
        do_req(1, 34'h2_8000_0010, REQ_EXEC, 8'hC3, 1'b1, g_err, g_eid, lat);
        #1;
        check("clrnew_valid", 128'(err_valid_o), 128'(1));
        check("clrnew_drop", 128'(err_drop_o), 128'(0));
        check("clrnew_rec", 128'(err_rec_o), 128'(clr_rec));

        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        #1;
        check("clr_valid", 128'(err_valid_o), 128'(0));
        check("clr_drop", 128'(err_drop_o), 128'(0));
        check("clr_rec_retained", 128'(err_rec_o), 128'(clr_rec));

        cfg_eid = 9'h0AB;
        resp_ready_i[3] = 1'b0;
        req_addr_i[3] = 34'h2_0000_0300; req_type_i[3] = REQ_WRITE; req_id_i[3] = 8'h3C;
        req_valid_i[3] = 1'b1;
        waited = 0;
        #1;
        while (!req_ready_o[3] && waited < 20) begin
            step();
            #1;
            waited++;
        end
        step();
        req_valid_i = 4'b0111;
        waited = 0;
        while (!resp_valid_o[3] && waited < 20) begin
            step();
            waited++;
        end
        if (!resp_valid_o[3]) timeout("bp_resp");
        for (int k = 0; k < 10; k++) begin
            #1;
            check("bp_resp_valid", 128'(resp_valid_o), 128'(4'b1000));
            check("bp_resp_err", 128'(resp_err_o), 128'(4'b1000));
            check("bp_resp_eid", 128'(resp_eid_o[3]), 128'(9'h0AB));
            check("bp_no_ready", 128'(req_ready_o), 128'(0));
            check("bp_no_launch", 128'(chk_valid_o), 128'(0));
            step();
        end
        req_valid_i = '0;
        resp_ready_i[3] = 1'b1;
        step();
        repeat (2) step();

        cfg_eid = '0;
        req_addr_i[1] = 34'h1_0000_0000; req_type_i[1] = REQ_READ; req_id_i[1] = 8'h21;
        req_addr_i[3] = 34'h0_0000_0300; req_type_i[3] = REQ_READ; req_id_i[3] = 8'h23;
        req_valid_i = 4'b0010;
        waited = 0;
        #1;
        while (!req_ready_o[1] && waited < 20) begin
            step();
            #1;
            waited++;
        end
        step();
        req_valid_i = '0;
        step();
        req_valid_i = 4'b1010;
        rst = 1'b0;
        #1;
        check("arst_req_ready", 128'(req_ready_o), 128'(0));
        check("arst_chk_valid", 128'(chk_valid_o), 128'(0));
        check("arst_chk_addr", 128'(chk_addr_o), 128'(0));
        check("arst_chk_chan", 128'(chk_chan_o), 128'(0));
        check("arst_resp_valid", 128'(resp_valid_o), 128'(0));
        check("arst_err_valid", 128'(err_valid_o), 128'(0));
        check("arst_err_rec", 128'(err_rec_o), 128'(0));
        check("arst_err_drop", 128'(err_drop_o), 128'(0));
        repeat (2) step();
        rst = 1'b1;
        #1;
        check("post_rst_grant", 128'(req_ready_o), 128'(4'b0010));
        step();
        req_valid_i = '0;
        repeat (8) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
